control_riesgos: RTL and testbench

//  Hazard/stall controller; handles the hazards that operand forwarding cannot resolve.

---
 rtl/control_riesgos.sv | 118 +++++++++++
 tb/tb_control_riesgos.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/control_riesgos.sv
// Hazard/stall controller for the 5-stage filter pipeline: load-use stalls, memory-wait
// freeze, taken-branch flush and saturating stall/flush event counters.
module control_riesgos #(
  parameter int LOAD_LAT = 2,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       Ra_F_Reg,
  input  logic             RE_A_F_Reg,
  input  logic [3:0]       Rb_F_Reg,
  input  logic             RE_B_F_Reg,
  input  logic [3:0]       Robj_Reg_Exe,
  input  logic             WE_Reg_Exe,
  input  logic             mem_RE_Reg_Exe,
  input  logic             branch_taken,
  input  logic             mem_busy,
  output logic             pc_en,
  output logic             en_F_Reg,
  output logic             en_pipe,
  output logic             flush_F_Reg,
  output logic             bubble_Reg_Exe,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic [1:0] {RUN, LOAD_STALL, FREEZE} state_t;

  state_t           state_q, state_d;
  state_t           saved_q, saved_d;
  state_t           eff_state;
  logic [3:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;
  logic             hazard;
  logic             pc_en_c, en_f_c, en_pipe_c, flush_c, bubble_c;

  assign hazard = mem_RE_Reg_Exe & WE_Reg_Exe &
                  (((Ra_F_Reg == Robj_Reg_Exe) & RE_A_F_Reg) |
                   ((Rb_F_Reg == Robj_Reg_Exe) & RE_B_F_Reg));

  // Leaving FREEZE resumes the saved state and applies its rules in the same cycle.
  assign eff_state = (state_q == FREEZE) ? saved_q : state_q;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
    state_d   = state_q;
    saved_d   = saved_q;
    cnt_d     = cnt_q;
    stall_d   = stall_q;
    flush_d   = flush_q;
    pc_en_c   = 1'b1;
    en_f_c    = 1'b1;
    en_pipe_c = 1'b1;
    flush_c   = 1'b0;
    bubble_c  = 1'b0;

    if (mem_busy) begin
      pc_en_c   = 1'b0;
      en_f_c    = 1'b0;
      en_pipe_c = 1'b0;
      saved_d   = eff_state;
      state_d   = FREEZE;
    end else begin
      state_d = eff_state;
      if (branch_taken) begin
        flush_c  = 1'b1;
        bubble_c = 1'b1;
        cnt_d    = '0;
        state_d  = RUN;
        if (flush_q != '1) flush_d = flush_q + CNT_W'(1);
      end else if (eff_state == LOAD_STALL) begin
        pc_en_c  = 1'b0;
        en_f_c   = 1'b0;
        bubble_c = 1'b1;
        cnt_d    = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = RUN;
        if (stall_q != '1) stall_d = stall_q + CNT_W'(1);
      end else if (hazard) begin
        pc_en_c  = 1'b0;
        en_f_c   = 1'b0;
        bubble_c = 1'b1;
        if (stall_q != '1) stall_d = stall_q + CNT_W'(1);
        if (LOAD_LAT > 1) begin
          cnt_d   = 4'(LOAD_LAT - 1);
          state_d = LOAD_STALL;
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      saved_q <= RUN;
      cnt_q   <= '0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      saved_q <= saved_d;
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  // While reset is low the pipe is held and F/Reg, Reg/Exe are forced to NOP.
  assign pc_en          = rst_n & pc_en_c;
  assign en_F_Reg       = rst_n & en_f_c;
  assign en_pipe        = rst_n & en_pipe_c;
  assign flush_F_Reg    = ~rst_n | flush_c;
  assign bubble_Reg_Exe = ~rst_n | bubble_c;
  assign stall_count    = stall_q;
  assign flush_count    = flush_q;

endmodule

// File: tb/tb_control_riesgos.sv
// Self-checking bench for control_riesgos: vector table through a scoreboard queue plus
// hand-written reset-mid-stall and counter-saturation sequences.
module tb_control_riesgos;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [3:0]       ra, rb, robj;
  logic             re_a, re_b, we, mre, br, busy;
  logic             pc_en, en_f, en_pipe, flush, bubble;
  logic [CNT_W-1:0] stall_count, flush_count;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  control_riesgos #(.LOAD_LAT(2), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .Ra_F_Reg(ra), .RE_A_F_Reg(re_a), .Rb_F_Reg(rb), .RE_B_F_Reg(re_b),
    .Robj_Reg_Exe(robj), .WE_Reg_Exe(we), .mem_RE_Reg_Exe(mre),
    .branch_taken(br), .mem_busy(busy),
    .pc_en(pc_en), .en_F_Reg(en_f), .en_pipe(en_pipe),
    .flush_F_Reg(flush), .bubble_Reg_Exe(bubble),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  typedef struct {
    string      name;
    logic [3:0] ra;
    logic       re_a;
    logic [3:0] rb;
    logic       re_b;
    logic [3:0] robj;
    logic       we;
    logic       mre;
    logic       br;
    logic       busy;
    logic [4:0] ctl;  // {pc_en, en_F_Reg, en_pipe, flush_F_Reg, bubble_Reg_Exe}
    int         st;
    int         fl;
  } vec_t;

  localparam logic [4:0] C_RUN   = 5'b11100;
  localparam logic [4:0] C_STALL = 5'b00101;
  localparam logic [4:0] C_FLUSH = 5'b11111;
  localparam logic [4:0] C_FRZ   = 5'b00000;
  localparam logic [4:0] C_RST   = 5'b00011;

  vec_t tbl[$];
  vec_t sb[$];

  function automatic vec_t mk(string n, logic [3:0] a, logic ea, logic [3:0] b, logic eb,
                              logic [3:0] o, logic w, logic m, logic bt, logic bz,
                              logic [4:0] c, int s, int f);
    vec_t v;
    v.name = n; v.ra = a; v.re_a = ea; v.rb = b; v.re_b = eb; v.robj = o;
    v.we = w; v.mre = m; v.br = bt; v.busy = bz; v.ctl = c; v.st = s; v.fl = f;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(vec_t v);
    ra = v.ra; re_a = v.re_a; rb = v.rb; re_b = v.re_b; robj = v.robj;
    we = v.we; mre = v.mre; br = v.br; busy = v.busy;
  endtask

  function automatic logic [4:0] ctl_now();
    return {pc_en, en_f, en_pipe, flush, bubble};
  endfunction

  initial begin
    #1ms;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t e;
    // name, ra, re_a, rb, re_b, robj, we, mre, br, busy, ctl, stall, flush
    tbl.push_back(mk("idle",           0, 0, 0, 0, 0, 0, 0, 0, 0, C_RUN,   0, 0));
    tbl.push_back(mk("ld_use_a_1",     3, 1, 0, 0, 3, 1, 1, 0, 0, C_STALL, 0, 0));
    tbl.push_back(mk("ld_use_a_2",     3, 1, 0, 0, 3, 1, 1, 0, 0, C_STALL, 1, 0));
    tbl.push_back(mk("ld_use_done",    0, 0, 0, 0, 0, 0, 0, 0, 0, C_RUN,   2, 0));
    tbl.push_back(mk("re_a_off",       3, 0, 0, 0, 3, 1, 1, 0, 0, C_RUN,   2, 0));
    tbl.push_back(mk("we_off",         3, 1, 0, 0, 3, 0, 1, 0, 0, C_RUN,   2, 0));
    tbl.push_back(mk("ld_use_b_1",     0, 0, 3, 1, 3, 1, 1, 0, 0, C_STALL, 2, 0));
    tbl.push_back(mk("ld_use_b_2",     0, 0, 0, 0, 0, 0, 0, 0, 0, C_STALL, 3, 0));
    tbl.push_back(mk("br_over_hazard", 3, 1, 0, 0, 3, 1, 1, 1, 0, C_FLUSH, 4, 0));
    tbl.push_back(mk("after_br",       0, 0, 0, 0, 0, 0, 0, 0, 0, C_RUN,   4, 1));
    tbl.push_back(mk("ld_use_3",       3, 1, 0, 0, 3, 1, 1, 0, 0, C_STALL, 4, 1));
    tbl.push_back(mk("busy_ls_1",      3, 1, 0, 0, 3, 1, 1, 0, 1, C_FRZ,   5, 1));
    tbl.push_back(mk("busy_ls_2",      3, 1, 0, 0, 3, 1, 1, 0, 1, C_FRZ,   5, 1));
    tbl.push_back(mk("busy_ls_3",      3, 1, 0, 0, 3, 1, 1, 0, 1, C_FRZ,   5, 1));
    tbl.push_back(mk("resume_ls",      3, 1, 0, 0, 3, 1, 1, 0, 0, C_STALL, 5, 1));
    tbl.push_back(mk("resume_run",     0, 0, 0, 0, 0, 0, 0, 0, 0, C_RUN,   6, 1));
    tbl.push_back(mk("busy_run",       0, 0, 0, 0, 0, 0, 0, 0, 1, C_FRZ,   6, 1));
    tbl.push_back(mk("unfreeze_hz",    3, 1, 0, 0, 3, 1, 1, 0, 0, C_STALL, 6, 1));
    tbl.push_back(mk("br_in_ls",       0, 0, 0, 0, 0, 0, 0, 1, 0, C_FLUSH, 7, 1));
    tbl.push_back(mk("after_br_ls",    0, 0, 0, 0, 0, 0, 0, 0, 0, C_RUN,   7, 2));
    tbl.push_back(mk("busy_over_br",   0, 0, 0, 0, 0, 0, 0, 1, 1, C_FRZ,   7, 2));
    tbl.push_back(mk("unfreeze_run",   0, 0, 0, 0, 0, 0, 0, 0, 0, C_RUN,   7, 2));
    tbl.push_back(mk("re_b_off",       5, 1, 3, 0, 3, 1, 1, 0, 0, C_RUN,   7, 2));
    tbl.push_back(mk("not_load",       3, 1, 3, 1, 3, 1, 0, 0, 0, C_RUN,   7, 2));

    // Reset state
    rst_n = 1'b0;
    drive(tbl[0]);
    #1;
    check("rst_ctl",   32'(ctl_now()), 32'(C_RST));
    check("rst_stall", 32'(stall_count), 0);
    check("rst_flush", 32'(flush_count), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      if (i != 0) @(negedge clk);
      drive(tbl[i]);
      sb.push_back(tbl[i]);
      #2;
      e = sb.pop_front();
      check({e.name, "_ctl"},   32'(ctl_now()),   32'(e.ctl));
      check({e.name, "_stall"}, 32'(stall_count), 32'(e.st));
      check({e.name, "_flush"}, 32'(flush_count), 32'(e.fl));
    end

    // Asynchronous reset in the middle of a load stall
    @(negedge clk);
    drive(tbl[1]);
    @(negedge clk);
    #1;
    check("mid_ls_ctl", 32'(ctl_now()), 32'(C_STALL));
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_ctl",   32'(ctl_now()), 32'(C_RST));
    check("async_rst_stall", 32'(stall_count), 0);
    check("async_rst_flush", 32'(flush_count), 0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(tbl[0]);
    #1;
    check("post_rst_ctl",   32'(ctl_now()), 32'(C_RUN));
    check("post_rst_stall", 32'(stall_count), 0);
    @(negedge clk);
    #1;
    check("post_rst_run", 32'(ctl_now()), 32'(C_RUN));

    // Flush counter saturation
    for (int i = 0; i < (1 << CNT_W) - 1; i++) begin
      @(negedge clk);
      br = 1'b1;
    end
    @(negedge clk);
    #1;
    check("sat_reach", 32'(flush_count), 32'((1 << CNT_W) - 1));
    check("sat_ctl",   32'(ctl_now()),   32'(C_FLUSH));
    @(negedge clk);
    br = 1'b0;
    #1;
    check("sat_hold",  32'(flush_count), 32'((1 << CNT_W) - 1));
    check("sat_stall", 32'(stall_count), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
